// File: rtl/gain_ctrl.sv
// gain_ctrl: user/host gain level control with mute and a slew-limited ramp
// toward the active target (0 while muted, otherwise the user level).
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   host_req   host gain-write request, held with host_gain until host_ack
//   host_gain  requested gain level (unsigned, clamped to MAX_GAIN)
//   host_ack   one-cycle acceptance pulse
//   btn_up     single-cycle pulse: level += BTN_STEP (clamped)
//   btn_down   single-cycle pulse: level -= BTN_STEP (floored at 0)
//   btn_mute   single-cycle pulse: toggle mute
//   gain_out   ramped gain code for the datapath (unity = UNITY_GAIN)
//   busy       high while ramping
//   muted      high while muted and fully ramped down to 0
module gain_ctrl #(
    parameter logic [19:0] UNITY_GAIN = 20'd8192,
    parameter logic [19:0] MAX_GAIN   = 20'd65535,
    parameter logic [19:0] BTN_STEP   = 20'd512,
    parameter logic [19:0] RAMP_STEP  = 20'd256,
    parameter int unsigned RAMP_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic [19:0] host_gain,
    output logic        host_ack,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_mute,
    output logic [19:0] gain_out,
    output logic        busy,
    output logic        muted
);

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        MUTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [19:0]        level_q, level_d;
    logic               mute_q, mute_d;
    logic [19:0]        gain_q, gain_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               host_ack_q, host_ack_d;

    logic               host_accept;
    logic [20:0]        level_sum;
    logic [19:0]        target_q, target_d;

    always_comb begin
        host_accept = host_req && !host_ack_q;
        host_ack_d  = host_accept;
        level_sum   = {1'b0, level_q} + {1'b0, BTN_STEP};

        // Host acceptance takes priority and swallows any button pulse.
        level_d = level_q;
        if (host_accept) begin
            level_d = (host_gain > MAX_GAIN) ? MAX_GAIN : host_gain;
        end else if (btn_up && !btn_down) begin
            level_d = (level_sum > {1'b0, MAX_GAIN}) ? MAX_GAIN : level_sum[19:0];
        end else if (btn_down && !btn_up) begin
            level_d = (level_q >= BTN_STEP) ? (level_q - BTN_STEP) : '0;
        end

        mute_d   = mute_q ^ btn_mute;
        target_q = mute_q ? '0 : level_q;

        // Ramp works from registered gain/target; direction re-evaluated each step.
        gain_d    = gain_q;
        div_cnt_d = '0;
        if (gain_q != target_q) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (target_q > gain_q) begin
                    gain_d = ((target_q - gain_q) <= RAMP_STEP) ? target_q : (gain_q + RAMP_STEP);
                end else begin
                    gain_d = ((gain_q - target_q) <= RAMP_STEP) ? target_q : (gain_q - RAMP_STEP);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        // State is derived from next-cycle values so it always matches the
        // registered gain/target/mute it is presented alongside.
        target_d = mute_d ? '0 : level_d;
        if (mute_d && (gain_d == '0)) begin
            state_d = MUTED;
        end else if (!mute_d && (gain_d == target_d)) begin
            state_d = IDLE;
        end else begin
            state_d = RAMP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RAMP;
            level_q    <= UNITY_GAIN;
            mute_q     <= 1'b0;
            gain_q     <= '0;
            div_cnt_q  <= '0;
            host_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            mute_q     <= mute_d;
            gain_q     <= gain_d;
            div_cnt_q  <= div_cnt_d;
            host_ack_q <= host_ack_d;
        end
    end

    assign gain_out = gain_q;
    assign host_ack = host_ack_q;
    assign busy     = (state_q == RAMP);
    assign muted    = (state_q == MUTED);

endmodule

// File: tb/tb_gain_ctrl.sv
// Directed bench for gain_ctrl with default parameters: a table of level
// updates checked through the settled gain_out, plus hand-written sequences
// for soft start, ramp latency, mute, handshake and mid-ramp reset.
module tb_gain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req;
    logic [19:0] host_gain;
    logic        host_ack;
    logic        btn_up;
    logic        btn_down;
    logic        btn_mute;
    logic [19:0] gain_out;
    logic        busy;
    logic        muted;

    int checks = 0;
    int errors = 0;

    gain_ctrl #(
        .UNITY_GAIN(20'd8192),
        .MAX_GAIN  (20'd65535),
        .BTN_STEP  (20'd512),
        .RAMP_STEP (20'd256),
        .RAMP_DIV  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .host_req (host_req),
        .host_gain(host_gain),
        .host_ack (host_ack),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_mute (btn_mute),
        .gain_out (gain_out),
        .busy     (busy),
        .muted    (muted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [19:0] gain;
        logic        up;
        logic        down;
        logic [19:0] exp_gain;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus; host_req is dropped once its ack is up.
    task automatic apply(input logic req, input logic [19:0] g, input logic up, input logic down);
        host_req  = req;
        host_gain = g;
        btn_up    = up;
        btn_down  = down;
        tick();
        host_req = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            tick();
        end
        check("settle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Soft start after reset release: one 256 step every 4 edges, done at 128.
    task automatic soft_start(input string tag);
        for (int k = 1; k <= 128; k++) begin
            tick();
            check({tag, "_gain"}, {12'd0, gain_out}, (k / 4) * 256);
            check({tag, "_busy"}, {31'd0, busy}, (k < 128) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int acks;
        int exp_g;

        // level after each vector, starting from a settled 8192
        vecs[0] = '{1'b0, 20'd0,      1'b0, 1'b1, 20'd7680};
        vecs[1] = '{1'b1, 20'hFFFFF,  1'b0, 1'b0, 20'd65535};
        vecs[2] = '{1'b0, 20'd0,      1'b1, 1'b0, 20'd65535};
        vecs[3] = '{1'b1, 20'd256,    1'b0, 1'b0, 20'd256};
        vecs[4] = '{1'b0, 20'd0,      1'b0, 1'b1, 20'd0};
        vecs[5] = '{1'b1, 20'd65280,  1'b0, 1'b0, 20'd65280};
        vecs[6] = '{1'b0, 20'd0,      1'b1, 1'b0, 20'd65535};
        vecs[7] = '{1'b1, 20'd2000,   1'b1, 1'b0, 20'd2000};
        vecs[8] = '{1'b0, 20'd0,      1'b1, 1'b1, 20'd2000};
        vecs[9] = '{1'b1, 20'd0,      1'b0, 1'b0, 20'd0};

        rst       = 1'b1;
        host_req  = 1'b0;
        host_gain = '0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_mute  = 1'b0;

        #12;
        check("rst_gain",  {12'd0, gain_out}, 32'd0);
        check("rst_busy",  {31'd0, busy},     32'd1);
        check("rst_muted", {31'd0, muted},    32'd0);
        check("rst_ack",   {31'd0, host_ack}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        soft_start("soft");

        for (int v = 0; v < 10; v++) begin
            apply(vecs[v].req, vecs[v].gain, vecs[v].up, vecs[v].down);
            check($sformatf("vec%0d_ack", v), {31'd0, host_ack}, {31'd0, vecs[v].req});
            settle();
            check($sformatf("vec%0d_gain", v), {12'd0, gain_out}, {12'd0, vecs[v].exp_gain});
        end

        // Host write 1000 from 0: steps land 4, 8, 12, 16 edges after acceptance.
        acks = 0;
        apply(1'b1, 20'd1000, 1'b0, 1'b0);
        acks += host_ack;
        for (int k = 1; k <= 16; k++) begin
            tick();
            acks += host_ack;
            if (k % 4 == 0) begin
                exp_g = (k == 16) ? 1000 : k * 64;
                check($sformatf("h1000_step%0d", k / 4), {12'd0, gain_out}, exp_g);
            end
        end
        check("h1000_ack_count", acks, 32'd1);
        check("h1000_idle", {31'd0, busy}, 32'd0);

        // Mute from 8192: 32 steps of 4 edges down to 0.
        apply(1'b1, 20'd8192, 1'b0, 1'b0);
        settle();
        btn_mute = 1'b1;
        tick();
        btn_mute = 1'b0;
        check("mute_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 127; k++) tick();
        tick();
        check("mute_pre_gain",  {12'd0, gain_out}, 32'd256);
        check("mute_pre_muted", {31'd0, muted},    32'd0);
        tick();
        check("mute_gain",  {12'd0, gain_out}, 32'd0);
        check("mute_muted", {31'd0, muted},    32'd1);
        check("mute_busy0", {31'd0, busy},     32'd0);

        apply(1'b0, 20'd0, 1'b1, 1'b0);
        repeat (10) tick();
        check("muted_up_gain",  {12'd0, gain_out}, 32'd0);
        check("muted_up_muted", {31'd0, muted},    32'd1);

        btn_mute = 1'b1;
        tick();
        btn_mute = 1'b0;
        check("unmute_busy",  {31'd0, busy},  32'd1);
        check("unmute_muted", {31'd0, muted}, 32'd0);
        settle();
        check("unmute_gain", {12'd0, gain_out}, 32'd8704);
        check("unmute_idle", {31'd0, busy},     32'd0);

        // host_req held for three edges: accepted on the 1st and 3rd.
        host_gain = 20'd3000;
        host_req  = 1'b1;
        tick();
        check("hold_ack1", {31'd0, host_ack}, 32'd1);
        tick();
        check("hold_ack2", {31'd0, host_ack}, 32'd0);
        tick();
        check("hold_ack3", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        tick();
        check("hold_ack4", {31'd0, host_ack}, 32'd0);
        settle();
        check("hold_gain", {12'd0, gain_out}, 32'd3000);

        // Reset mid-ramp at 4096 with a host request pending.
        apply(1'b1, 20'd0, 1'b0, 1'b0);
        settle();
        apply(1'b1, 20'd8192, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (gain_out == 20'd4096) break;
            tick();
        end
        check("mid_reach_4096", {12'd0, gain_out}, 32'd4096);
        host_gain = 20'd5000;
        host_req  = 1'b1;
        rst       = 1'b1;
        #1;
        check("mid_rst_gain", {12'd0, gain_out}, 32'd0);
        check("mid_rst_busy", {31'd0, busy},     32'd1);
        check("mid_rst_ack",  {31'd0, host_ack}, 32'd0);
        @(negedge clk);
        host_req = 1'b0;
        rst      = 1'b0;
        soft_start("resoft");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
